reporte_estado_uart: RTL and testbench

Serial status reporter for the temperature monitor: captures the FSM state, the alert and actuator flags, and the registered temperature, then transmits them as a framed 8N1 UART packet. It sits downstream of the temperature state machine and is the transmit end of the monitor-to-host link. It sends a report on a state change, on a periodic timer, or on explicit request.

---
 rtl/reporte_pkg.sv | 36 +++
 rtl/uart_tx_byte.sv | 90 +++++++++
 rtl/reporte_estado_uart.sv | 103 ++++++++++
 tb/tb_reporte_estado_uart.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reporte_pkg.sv
// Shared definitions for the status reporter: serializer states, frame layout and
// the temperature-state encoding. NBYTES depends on REPORTE_CHECKSUM_EN.
package reporte_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_estado_t;

  // Encoding shared with the temperature state machine.
  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    BAJO   = 2'b01,
    ALTO   = 2'b10,
    ALERTA = 2'b11
  } estado_temp_t;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

`ifdef REPORTE_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif

  function automatic logic [7:0] armar_b1(input logic       alerta,
                                          input logic       calefactor,
                                          input logic       ventilador,
                                          input logic [1:0] estado,
                                          input logic [2:0] temp_msb);
    return {alerta, calefactor, ventilador, estado, temp_msb};
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with valid/listo handshake; a byte offered during the last
// cycle of a stop bit is taken without any idle gap.
module uart_tx_byte
  import reporte_pkg::*;
#(
  parameter int CICLOS_POR_BIT = 434
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       valid,
  input  logic [7:0] dato,
  output logic       listo,
  output logic       tx,
  output logic       ocupado,
  output logic       fin
);
  localparam int CW = $clog2(CICLOS_POR_BIT);

  uart_estado_t  estado_reg;
  logic [CW-1:0] cnt_bit_reg;
  logic [2:0]    n_bit_reg;
  logic [7:0]    shift_reg;
  logic          fin_bit;

  assign fin_bit = (cnt_bit_reg == CW'(CICLOS_POR_BIT - 1));
  assign listo   = (estado_reg == IDLE) || ((estado_reg == STOP) && fin_bit);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      estado_reg  <= IDLE;
      cnt_bit_reg <= '0;
      n_bit_reg   <= '0;
      shift_reg   <= '0;
      tx          <= 1'b1;
      ocupado     <= 1'b0;
      fin         <= 1'b0;
    end else begin
      fin <= 1'b0;
      if (valid && listo) begin
        estado_reg  <= START;
        cnt_bit_reg <= '0;
        n_bit_reg   <= '0;
        shift_reg   <= dato;
        tx          <= 1'b0;
        ocupado     <= 1'b1;
      end else begin
        case (estado_reg)
          START: begin
            if (fin_bit) begin
              cnt_bit_reg <= '0;
              estado_reg  <= DATA;
              tx          <= shift_reg[0];
            end else begin
              cnt_bit_reg <= cnt_bit_reg + CW'(1);
            end
          end
          DATA: begin
            if (fin_bit) begin
              cnt_bit_reg <= '0;
              if (n_bit_reg == 3'd7) begin
                n_bit_reg  <= '0;
                estado_reg <= STOP;
                tx         <= 1'b1;
              end else begin
                n_bit_reg <= n_bit_reg + 3'd1;
                shift_reg <= shift_reg >> 1;
                tx        <= shift_reg[1];
              end
            end else begin
              cnt_bit_reg <= cnt_bit_reg + CW'(1);
            end
          end
          STOP: begin
            // Reaching here with fin_bit means nobody offered another byte.
            if (fin_bit) begin
              cnt_bit_reg <= '0;
              estado_reg  <= IDLE;
              ocupado     <= 1'b0;
              fin         <= 1'b1;
            end else begin
              cnt_bit_reg <= cnt_bit_reg + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/reporte_estado_uart.sv
// Status reporter: triggers, single-slot pending flag, snapshot and byte sequencing.
// Define REPORTE_CHECKSUM_EN to append an XOR checksum byte to every frame.
module reporte_estado_uart
  import reporte_pkg::*;
#(
  parameter int CICLOS_POR_BIT  = 434,
  parameter int PERIODO_REPORTE = 50_000_000
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic signed [10:0] temp_registrado,
  input  logic [1:0]         estado_actual,
  input  logic               alerta,
  input  logic               calefactor,
  input  logic               ventilador,
  input  logic               solicitud,
  output logic               tx,
  output logic               ocupado,
  output logic               reporte_enviado
);
  logic [1:0] estado_prev_reg;
  logic       pendiente_reg;
  logic [1:0] byte_idx_reg;
  logic [7:0] snap_b1_reg;
  logic [7:0] snap_b2_reg;
  logic       wrap_periodo;
  logic       disparo;
  logic       inicio_trama;
  logic       byte_valido;
  logic       byte_listo;
  logic [7:0] dato_byte;

  generate
    if (PERIODO_REPORTE > 0) begin : g_periodo
      localparam int PW = (PERIODO_REPORTE > 1) ? $clog2(PERIODO_REPORTE) : 1;
      logic [PW-1:0] cnt_periodo_reg;

      assign wrap_periodo = (cnt_periodo_reg == PW'(PERIODO_REPORTE - 1));

      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)           cnt_periodo_reg <= '0;
        else if (wrap_periodo) cnt_periodo_reg <= '0;
        else                   cnt_periodo_reg <= cnt_periodo_reg + PW'(1);
      end
    end else begin : g_sin_periodo
      assign wrap_periodo = 1'b0;
    end
  endgenerate

  assign disparo      = (estado_actual != estado_prev_reg) || wrap_periodo || solicitud;
  assign inicio_trama = !ocupado && (disparo || pendiente_reg);
  // A nonzero index means the current frame still has bytes to hand over.
  assign byte_valido  = inicio_trama || (byte_idx_reg != 2'd0);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      estado_prev_reg <= NORMAL;
      pendiente_reg   <= 1'b0;
      byte_idx_reg    <= '0;
      snap_b1_reg     <= '0;
      snap_b2_reg     <= '0;
    end else begin
      estado_prev_reg <= estado_actual;
      if (inicio_trama) begin
        pendiente_reg <= 1'b0;
        snap_b1_reg   <= armar_b1(alerta, calefactor, ventilador, estado_actual,
                                  temp_registrado[10:8]);
        snap_b2_reg   <= temp_registrado[7:0];
      end else if (disparo) begin
        pendiente_reg <= 1'b1;
      end
      if (byte_valido && byte_listo) begin
        byte_idx_reg <= (byte_idx_reg == 2'(NBYTES - 1)) ? 2'd0 : byte_idx_reg + 2'd1;
      end
    end
  end

  always_comb begin
    dato_byte = HEADER_BYTE;
    case (byte_idx_reg)
      2'd1:    dato_byte = snap_b1_reg;
      2'd2:    dato_byte = snap_b2_reg;
`ifdef REPORTE_CHECKSUM_EN
      2'd3:    dato_byte = HEADER_BYTE ^ snap_b1_reg ^ snap_b2_reg;
`endif
      default: dato_byte = HEADER_BYTE;
    endcase
  end

  uart_tx_byte #(
    .CICLOS_POR_BIT(CICLOS_POR_BIT)
  ) u_tx (
    .clk     (clk),
    .arst_n  (arst_n),
    .valid   (byte_valido),
    .dato    (dato_byte),
    .listo   (byte_listo),
    .tx      (tx),
    .ocupado (ocupado),
    .fin     (reporte_enviado)
  );

endmodule

// File: tb/tb_reporte_estado_uart.sv
// Directed bench for reporte_estado_uart: vector table plus pending, periodic and reset sequences.
// Honours REPORTE_CHECKSUM_EN for the expected frame length and checksum byte.
module tb_reporte_estado_uart;
  localparam int CPB  = 4;
`ifdef REPORTE_CHECKSUM_EN
  localparam int NB   = 4;
`else
  localparam int NB   = 3;
`endif
  localparam int TRAMA = NB * 10 * CPB;
  localparam int NLOG  = 8192;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic signed [10:0] temp = '0;
  logic [1:0] estado = 2'b00;
  logic alerta = 1'b0, calefactor = 1'b0, ventilador = 1'b0, solicitud = 1'b0;
  logic tx, ocupado, reporte_enviado;

  logic solicitud_p = 1'b0;
  logic tx_p, ocupado_p, reporte_enviado_p;

  int ciclo = 0;
  int checks = 0;
  int failures = 0;
  logic tx_log [NLOG];
  logic oc_log [NLOG];
  logic re_log [NLOG];

  reporte_estado_uart #(.CICLOS_POR_BIT(CPB), .PERIODO_REPORTE(0)) dut (
    .clk(clk), .arst_n(arst_n), .temp_registrado(temp), .estado_actual(estado),
    .alerta(alerta), .calefactor(calefactor), .ventilador(ventilador),
    .solicitud(solicitud), .tx(tx), .ocupado(ocupado), .reporte_enviado(reporte_enviado));

  reporte_estado_uart #(.CICLOS_POR_BIT(CPB), .PERIODO_REPORTE(200)) dut_p (
    .clk(clk), .arst_n(arst_n), .temp_registrado(11'sd77), .estado_actual(2'b00),
    .alerta(1'b0), .calefactor(1'b0), .ventilador(1'b0),
    .solicitud(solicitud_p), .tx(tx_p), .ocupado(ocupado_p), .reporte_enviado(reporte_enviado_p));

  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  always @(negedge clk) begin
    if (ciclo < NLOG) begin
      tx_log[ciclo] = tx;
      oc_log[ciclo] = ocupado;
      re_log[ciclo] = reporte_enviado;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: obtenido=timeout esperado=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]         estado;
    logic               alerta;
    logic               calefactor;
    logic               ventilador;
    logic signed [10:0] temp;
    logic               solic;
    logic [7:0]         b1;
    logic [7:0]         b2;
  } vector_t;

  vector_t vec [6];

  task automatic chk(input string nombre, input int actual, input int esperado);
    checks++;
    if (actual !== esperado) begin
      failures++;
      $display("FAIL %s: obtenido=%0h esperado=%0h", nombre, actual, esperado);
    end
  endtask

  task automatic esperar_fin(input string nombre, input int limite, output int t_fin);
    t_fin = -1;
    for (int i = 0; i < limite; i++) begin
      @(negedge clk);
      if (reporte_enviado === 1'b1) begin
        t_fin = ciclo;
        break;
      end
    end
    if (t_fin < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: obtenido=sin_pulso esperado=reporte_enviado", nombre);
    end
  endtask

  task automatic esperar_inicio_p(input string nombre, input int limite, output int t);
    logic prev;
    prev = ocupado_p;
    t = -1;
    for (int i = 0; i < limite; i++) begin
      @(negedge clk);
      if (ocupado_p === 1'b1 && prev === 1'b0) begin
        t = ciclo;
        break;
      end
      prev = ocupado_p;
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: obtenido=sin_trama esperado=trama", nombre);
    end
  endtask

  function automatic int decodificar(input int ini, input int j);
    int base, valor;
    logic nivel;
    base  = ini + j * 10 * CPB;
    valor = 0;
    if (base < 0 || base + 10 * CPB > NLOG) return -2;
    for (int b = 0; b < 10; b++) begin
      nivel = tx_log[base + b * CPB];
      for (int c = 1; c < CPB; c++)
        if (tx_log[base + b * CPB + c] !== nivel) return -1;
      if (b == 0 && nivel !== 1'b0) return -1;
      if (b == 9 && nivel !== 1'b1) return -1;
      if (b >= 1 && b <= 8 && nivel === 1'b1) valor |= (1 << (b - 1));
    end
    return valor;
  endfunction

  function automatic int contar_pulsos(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++)
      if (k >= 0 && k < NLOG && re_log[k] === 1'b1) n++;
    return n;
  endfunction

  task automatic verificar_trama(input string nombre, input int ini,
                                 input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] esp [4];
    esp[0] = 8'hA5;
    esp[1] = e1;
    esp[2] = e2;
    esp[3] = 8'hA5 ^ e1 ^ e2;
    for (int j = 0; j < NB; j++)
      chk($sformatf("%s_b%0d", nombre, j), decodificar(ini, j), int'(esp[j]));
  endtask

  initial begin
    int t0, t_fin, t_fin2, s1, s2, s3, n_oc, n_re;

    vec[0] = '{2'b10, 1'b1, 1'b0, 1'b1, 11'sd300,  1'b0, 8'hB1, 8'h2C};
    vec[1] = '{2'b01, 1'b1, 1'b0, 1'b1, 11'sd300,  1'b0, 8'hA9, 8'h2C};
    vec[2] = '{2'b11, 1'b1, 1'b1, 1'b0, -11'sd50,  1'b0, 8'hDF, 8'hCE};
    vec[3] = '{2'b00, 1'b0, 1'b1, 1'b0, 11'sd0,    1'b0, 8'h40, 8'h00};
    vec[4] = '{2'b00, 1'b0, 1'b0, 1'b0, 11'sd1023, 1'b1, 8'h03, 8'hFF};
    vec[5] = '{2'b10, 1'b0, 1'b0, 1'b1, 11'h400,   1'b0, 8'h34, 8'h00};

    // Reset state and quiet idle afterwards.
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_ocupado", ocupado, 0);
    chk("reset_enviado", reporte_enviado, 0);
    arst_n = 1'b1;
    n_oc = 0;
    repeat (20) begin
      @(negedge clk);
      if (ocupado) n_oc++;
    end
    chk("idle_tras_reset", n_oc, 0);

    // Table-driven frames.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      estado = vec[i].estado; alerta = vec[i].alerta; calefactor = vec[i].calefactor;
      ventilador = vec[i].ventilador; temp = vec[i].temp; solicitud = vec[i].solic;
      t0 = ciclo;
      @(negedge clk);
      solicitud = 1'b0;
      chk($sformatf("v%0d_inicio_ocupado", i), ocupado, 1);
      chk($sformatf("v%0d_inicio_tx", i), tx, 0);
      esperar_fin($sformatf("v%0d", i), TRAMA + 20, t_fin);
      @(negedge clk);
      chk($sformatf("v%0d_fin_ciclo", i), t_fin, t0 + 1 + TRAMA);
      verificar_trama($sformatf("v%0d", i), t0 + 1, vec[i].b1, vec[i].b2);
      chk($sformatf("v%0d_pulsos", i), contar_pulsos(t0, t_fin), 1);
      $display("vector %0d: b1=%02h b2=%02h inicio=%0d fin=%0d", i, vec[i].b1, vec[i].b2, t0 + 1, t_fin);
      repeat (5) @(negedge clk);
    end

    // Three requests and a temperature change mid-frame: one follow-up frame.
    @(negedge clk);
    alerta = 1'b0; calefactor = 1'b0; ventilador = 1'b0; temp = 11'sd300; solicitud = 1'b1;
    t0 = ciclo;
    @(negedge clk); solicitud = 1'b0;
    repeat (9) @(negedge clk); solicitud = 1'b1;
    @(negedge clk); solicitud = 1'b0;
    repeat (30) @(negedge clk); temp = 11'sd150;
    repeat (10) @(negedge clk); solicitud = 1'b1;
    @(negedge clk); solicitud = 1'b0;
    repeat (30) @(negedge clk); solicitud = 1'b1;
    @(negedge clk); solicitud = 1'b0;
    esperar_fin("pend1", TRAMA, t_fin);
    esperar_fin("pend2", TRAMA + 20, t_fin2);
    @(negedge clk);
    chk("pend1_fin_ciclo", t_fin, t0 + 1 + TRAMA);
    verificar_trama("pend1", t0 + 1, 8'h11, 8'h2C);
    chk("pend2_ocupado_gap", oc_log[t_fin], 0);
    chk("pend2_inicio_ocupado", oc_log[t_fin + 1], 1);
    chk("pend2_inicio_tx", tx_log[t_fin + 1], 0);
    chk("pend2_fin_ciclo", t_fin2, t_fin + 1 + TRAMA);
    verificar_trama("pend2", t_fin + 1, 8'h10, 8'h96);
    n_oc = 0;
    repeat (200) begin
      @(negedge clk);
      if (ocupado) n_oc++;
    end
    chk("pend_sin_tercera", n_oc, 0);
    $display("pendiente: fin1=%0d fin2=%0d", t_fin, t_fin2);

    // Periodic instance: spacing, and a request coinciding with the wrap.
    esperar_inicio_p("per1", 450, s1);
    esperar_inicio_p("per2", 450, s2);
    chk("per_intervalo", s2 - s1, 200);
    while (ciclo < s2 + 199) @(negedge clk);
    solicitud_p = 1'b1;
    @(negedge clk);
    solicitud_p = 1'b0;
    chk("per_inicio_con_solicitud", ocupado_p, 1);
    esperar_inicio_p("per3", 450, s3);
    chk("per_sin_duplicado", s3 - s2, 400);
    $display("periodico: s1=%0d s2=%0d s3=%0d", s1, s2, s3);

    // Reset during DATA of B1 with a request pending.
    @(negedge clk);
    estado = 2'b00;
    t0 = ciclo;
    repeat (5) @(negedge clk); solicitud = 1'b1;
    @(negedge clk); solicitud = 1'b0;
    while (ciclo < t0 + 55) @(negedge clk);
    chk("rst_antes_ocupado", ocupado, 1);
    chk("rst_antes_tx", tx, 0);
    #1 arst_n = 1'b0;
    #1;
    chk("rst_async_tx", tx, 1);
    chk("rst_async_ocupado", ocupado, 0);
    n_oc = 0;
    n_re = 0;
    repeat (3) begin
      @(negedge clk);
      if (reporte_enviado) n_re++;
    end
    arst_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (ocupado) n_oc++;
      if (reporte_enviado) n_re++;
    end
    chk("rst_sin_trama", n_oc, 0);
    chk("rst_sin_pulso", n_re, 0);
    $display("reset en trama: t0=%0d", t0);

    // Nonzero state straight out of reset reports once.
    @(negedge clk);
    #1 arst_n = 1'b0;
    estado = 2'b11; alerta = 1'b0; calefactor = 1'b1; ventilador = 1'b1; temp = -11'sd1;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    t0 = ciclo;
    @(negedge clk);
    chk("post_rst_ocupado", ocupado, 1);
    chk("post_rst_tx", tx, 0);
    esperar_fin("post_rst", TRAMA + 20, t_fin);
    @(negedge clk);
    chk("post_rst_fin_ciclo", t_fin, t0 + 1 + TRAMA);
    verificar_trama("post_rst", t0 + 1, 8'h7F, 8'hFF);
    $display("post reset: inicio=%0d fin=%0d", t0 + 1, t_fin);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
